// File: rtl/trx_control_axil_slave.sv
// trx_control_axil_slave
//
// AXI4-Lite responder for the transceiver control path. It decodes 32-bit
// word accesses into a small register file, drives the control fields of the
// TRX datapath, and returns live status plus sticky, maskable event flags.
//
// Register map (word index = ADDR[4:2], ADDR[1:0] ignored):
//   0x00 CTRL  rw       0x04 FREQ rw      0x08 GAIN rw     0x0C MODE rw
//   0x10 STATUS ro      (status_i sampled when the read address is taken)
//   0x14 IRQ   [7:0] flags W1C, [15:8] enable rw, [31:16] read as 0
//   0x18 ID    ro       (C_ID_VALUE)
//   0x1C reserved
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock and asynchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*   AXI4-Lite write channels
//   S_AXI_AR*, S_AXI_R*             AXI4-Lite read channels
//   ctrl_o, freq_o, gain_o, mode_o  contents of registers 0x00..0x0C
//   status_i                        live status word
//   event_i                         single-cycle event pulses
//   irq_o                           registered OR of (flags & enable)
//
// Optional feature macro: TRX_CTRL_ADDR_ERR_EN
//   defined     : accesses to 0x1C answer SLVERR (reads return 0)
//   not defined : every address answers OKAY, 0x1C reads 0
//
// Only a 32-bit data bus is supported.

module trx_control_axil_slave #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [31:0] C_ID_VALUE         = 32'h5452_0002
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     ctrl_o,
   output logic [31:0]                     freq_o,
   output logic [31:0]                     gain_o,
   output logic [31:0]                     mode_o,
   input  logic [31:0]                     status_i,
   input  logic [7:0]                      event_i,
   output logic                            irq_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic        rst_done;
   logic        aw_held, w_held;
   logic [2:0]  aw_idx_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        aw_hs, w_hs, ar_hs, commit;
   logic [2:0]  wr_idx, rd_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [31:0] ctrl_q, freq_q, gain_q, mode_q;
   logic [7:0]  flags_q, enable_q, flag_clr;
   logic [31:0] rd_mux;
   logic        bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Readies are gated by rst_done so they stay low while reset is held and
   // come up on the first edge after release.
   assign S_AXI_AWREADY = rst_done && !aw_held && !bvalid_q;
   assign S_AXI_WREADY  = rst_done && !w_held && !bvalid_q;
   assign S_AXI_ARREADY = rst_done && !rvalid_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // A write commits on the edge where the second half arrives (or both
   // arrive together), so address/data come from the holding register if
   // present and straight from the bus otherwise.
   assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[4:2];
   assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
   assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
   assign rd_idx  = S_AXI_ARADDR[4:2];

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

   function automatic logic is_reserved(input logic [2:0] idx);
`ifdef TRX_CTRL_ADDR_ERR_EN
      return idx == 3'd7;
`else
      return idx == 3'd7 && 1'b0;
`endif
   endfunction

   // Reset-release tracker that enables the ready outputs.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) rst_done <= 1'b0;
      else              rst_done <= 1'b1;
   end

   // One-entry holding registers for the write address and write data.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
      end
   end

   // Write response: raised on the commit edge, held until BREADY.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= is_reserved(wr_idx) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_q <= 1'b0;
      end
   end

   // W1C mask for the IRQ flags; only byte lane 0 can clear flags.
   always_comb begin
      flag_clr = 8'h00;
      if (commit && wr_idx == 3'd5 && wr_strb[0]) flag_clr = wr_data[7:0];
   end

   // Register file. New events are OR-ed in after the clear so a pulse that
   // coincides with a W1C of the same bit keeps the flag set.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         ctrl_q   <= '0;
         freq_q   <= '0;
         gain_q   <= '0;
         mode_q   <= '0;
         enable_q <= '0;
         flags_q  <= '0;
         irq_o    <= 1'b0;
      end else begin
         if (commit) begin
            case (wr_idx)
               3'd0: ctrl_q <= merge_bytes(ctrl_q, wr_data, wr_strb);
               3'd1: freq_q <= merge_bytes(freq_q, wr_data, wr_strb);
               3'd2: gain_q <= merge_bytes(gain_q, wr_data, wr_strb);
               3'd3: mode_q <= merge_bytes(mode_q, wr_data, wr_strb);
               3'd5: if (wr_strb[1]) enable_q <= wr_data[15:8];
               default: ;
            endcase
         end
         flags_q <= (flags_q & ~flag_clr) | event_i;
         irq_o   <= |(flags_q & enable_q);
      end
   end

   // Read data selection from the current (pre-commit) register values.
   always_comb begin
      rd_mux = 32'h0;
      case (rd_idx)
         3'd0: rd_mux = ctrl_q;
         3'd1: rd_mux = freq_q;
         3'd2: rd_mux = gain_q;
         3'd3: rd_mux = mode_q;
         3'd4: rd_mux = status_i;
         3'd5: rd_mux = {16'h0000, enable_q, flags_q};
         3'd6: rd_mux = C_ID_VALUE;
         default: rd_mux = 32'h0;
      endcase
   end

   // Read response: registered on the AR handshake edge, held until RREADY.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_mux;
         rresp_q  <= is_reserved(rd_idx) ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign ctrl_o       = ctrl_q;
   assign freq_o       = freq_q;
   assign gain_o       = gain_q;
   assign mode_o       = mode_q;

endmodule

// File: tb/tb_trx_control_axil_slave.sv
// tb_trx_control_axil_slave
//
// Self-checking bench for trx_control_axil_slave: table of register
// write/read vectors plus hand-written sequences for skewed writes, byte
// strobes, IRQ set/clear collisions and reset in the middle of traffic.
// Read expectations go through a scoreboard queue.

module tb_trx_control_axil_slave;

   localparam logic [31:0] ID_VALUE   = 32'h5452_0002;
   localparam logic [31:0] STATUS_VAL = 32'h1234_5678;
`ifdef TRX_CTRL_ADDR_ERR_EN
   localparam logic [1:0]  RSV_RESP   = 2'b10;
`else
   localparam logic [1:0]  RSV_RESP   = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [4:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] ctrl_o, freq_o, gain_o, mode_o;
   logic [31:0] status_i = STATUS_VAL;
   logic [7:0]  event_i = '0;
   logic        irq_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      string       name;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;
   vec_t vecs[7];

   trx_control_axil_slave dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .ctrl_o        (ctrl_o),
      .freq_o        (freq_o),
      .gain_o        (gain_o),
      .mode_o        (mode_o),
      .status_i      (status_i),
      .event_i       (event_i),
      .irq_o         (irq_o)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case a sequence stalls outside its own bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=stalled required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s actual=timeout required=handshake", name);
   endtask

   // Waits for BVALID (bounded), checks BRESP and completes the B handshake.
   task automatic waitB(input logic [1:0] exp_resp, input string name);
      int n = 0;
      while (!bvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bvalid) begin
         reportTimeout({name, "_b"});
         return;
      end
      checkOutput({name, "_bresp"}, {30'h0, bresp}, {30'h0, exp_resp});
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input string name);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs, w_hs;
      int n = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         n++;
      end
      if (!(aw_done && w_done)) begin
         awvalid = 1'b0; wvalid = 1'b0;
         reportTimeout({name, "_aw_w"});
         return;
      end
      waitB(exp_resp, name);
   endtask

   // Pushes the expectation, issues the read, then pops and compares once
   // RVALID shows up.
   task automatic axiRead(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input string name);
      exp_t e;
      bit   hs = 1'b0;
      int   n = 0;
      e.data = exp_data; e.resp = exp_resp; e.name = name;
      sb_q.push_back(e);
      araddr = addr; arvalid = 1'b1;
      while (!hs && n < 20) begin
         @(negedge clk);
         hs = arready;
         @(posedge clk); #1;
         n++;
      end
      arvalid = 1'b0;
      if (!hs) begin
         e = sb_q.pop_front();
         reportTimeout({name, "_ar"});
         return;
      end
      checkOutput({name, "_rlat"}, {31'h0, rvalid}, 32'h1);
      n = 0;
      while (!rvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      e = sb_q.pop_front();
      if (!rvalid) begin
         reportTimeout({e.name, "_r"});
         return;
      end
      checkOutput({e.name, "_rdata"}, rdata, e.data);
      checkOutput({e.name, "_rresp"}, {30'h0, rresp}, {30'h0, e.resp});
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      axiWrite(v.addr, v.wdata, v.wstrb, v.bresp, $sformatf("vec%0d_wr", idx));
   endtask

   initial begin
      bit hs;

      vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
      vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
      vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003, 2'b00};
      vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004, 2'b00};
      vecs[4] = '{5'h10, 32'hFFFF_FFFF, 4'hF, 2'b00, STATUS_VAL,    2'b00};
      vecs[5] = '{5'h18, 32'h0000_0000, 4'hF, 2'b00, ID_VALUE,      2'b00};
      vecs[6] = '{5'h1C, 32'hDEAD_BEEF, 4'hF, RSV_RESP, 32'h0,      RSV_RESP};

      // Reset state: readies low while reset is held, up one edge after release.
      #12;
      checkOutput("rst_awready_held", {31'h0, awready}, 32'h0);
      checkOutput("rst_arready_held", {31'h0, arready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_awready", {31'h0, awready}, 32'h1);
      checkOutput("rst_wready",  {31'h0, wready},  32'h1);
      checkOutput("rst_arready", {31'h0, arready}, 32'h1);
      checkOutput("rst_bvalid",  {31'h0, bvalid},  32'h0);
      checkOutput("rst_rvalid",  {31'h0, rvalid},  32'h0);
      checkOutput("rst_ctrl",    ctrl_o, 32'h0);
      checkOutput("rst_irq",     {31'h0, irq_o}, 32'h0);

      // Table: write every vector, then read every vector back.
      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);
      for (int i = 0; i < 7; i++)
         axiRead(vecs[i].addr, vecs[i].rdata, vecs[i].rresp, $sformatf("vec%0d_rd", i));
      checkOutput("ctrl_o", ctrl_o, 32'h0000_0001);
      checkOutput("freq_o", freq_o, 32'h0000_0002);
      checkOutput("gain_o", gain_o, 32'h0000_0003);
      checkOutput("mode_o", mode_o, 32'h0000_0004);
      // Low address bits are ignored: 0x0B aliases GAIN.
      axiRead(5'h0B, 32'h0000_0003, 2'b00, "alias_gain");

      // Byte strobes: only lane 1 of CTRL is written.
      axiWrite(5'h00, 32'h0000_0000, 4'hF, 2'b00, "strb_clear");
      axiWrite(5'h00, 32'hFFFF_FFFF, 4'b0010, 2'b00, "strb_lane1");
      checkOutput("strb_ctrl_o", ctrl_o, 32'h0000_FF00);
      axiRead(5'h00, 32'h0000_FF00, 2'b00, "strb_rd");

      // Skewed write: W three cycles ahead of AW.
      wdata = 32'hA5A5_0000; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk); hs = wready;
      @(posedge clk); #1;
      wvalid = 1'b0;
      checkOutput("skew_w_accept", {31'h0, hs}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("skew_no_b%0d", i), {31'h0, bvalid}, 32'h0);
         @(posedge clk); #1;
      end
      awaddr = 5'h04; awvalid = 1'b1;
      @(negedge clk); hs = awready;
      @(posedge clk); #1;
      awvalid = 1'b0;
      checkOutput("skew_aw_accept", {31'h0, hs}, 32'h1);
      checkOutput("skew_bvalid", {31'h0, bvalid}, 32'h1);
      checkOutput("skew_freq_o", freq_o, 32'hA5A5_0000);
      waitB(2'b00, "skew");

      // IRQ: enable bit 3, pulse event 3, irq follows one edge after the flag.
      axiWrite(5'h14, 32'h0000_0800, 4'b0010, 2'b00, "irq_en");
      event_i = 8'h08;
      @(posedge clk); #1;
      event_i = 8'h00;
      checkOutput("irq_latency", {31'h0, irq_o}, 32'h0);
      @(posedge clk); #1;
      checkOutput("irq_set", {31'h0, irq_o}, 32'h1);

      // W1C of bit 3 committing on the same edge as a fresh event 3 pulse.
      awaddr = 5'h14; wdata = 32'h0000_0008; wstrb = 4'b0001;
      awvalid = 1'b1; wvalid = 1'b1; event_i = 8'h08;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; event_i = 8'h00;
      checkOutput("irq_collide_commit", {31'h0, bvalid}, 32'h1);
      waitB(2'b00, "irq_collide");
      checkOutput("irq_collide_irq", {31'h0, irq_o}, 32'h1);
      axiRead(5'h14, 32'h0000_0808, 2'b00, "irq_collide_rd");

      // Plain W1C clears the flag.
      axiWrite(5'h14, 32'h0000_0008, 4'b0001, 2'b00, "irq_w1c");
      checkOutput("irq_cleared", {31'h0, irq_o}, 32'h0);
      axiRead(5'h14, 32'h0000_0800, 2'b00, "irq_w1c_rd");

      // Reset with a B response and an R response both pending.
      awaddr = 5'h0C; wdata = 32'h0000_0055; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 5'h00; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      checkOutput("mid_pre_bvalid", {31'h0, bvalid}, 32'h1);
      checkOutput("mid_pre_rvalid", {31'h0, rvalid}, 32'h1);
      checkOutput("mid_pre_mode",   mode_o, 32'h0000_0055);
      rst = 1'b1;
      #1;
      checkOutput("mid_bvalid",  {31'h0, bvalid},  32'h0);
      checkOutput("mid_rvalid",  {31'h0, rvalid},  32'h0);
      checkOutput("mid_awready", {31'h0, awready}, 32'h0);
      checkOutput("mid_rdata",   rdata,  32'h0);
      checkOutput("mid_ctrl",    ctrl_o, 32'h0);
      checkOutput("mid_freq",    freq_o, 32'h0);
      checkOutput("mid_mode",    mode_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("mid_awready_back", {31'h0, awready}, 32'h1);
      axiRead(5'h0C, 32'h0, 2'b00, "mid_mode_rd");
      axiRead(5'h14, 32'h0, 2'b00, "mid_irq_rd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
